// File: rtl/pipeifq_pkg.sv
// rtl/pipeifq_pkg.sv - shared fetch states and constants for the instruction prefetch queue
package pipeifq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no request outstanding
      ST_REQ  = 2'd1,   // request in flight, response will be queued
      ST_DROP = 2'd2    // request in flight, response belongs to a stale path
   } fetch_state_t;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   // Fetch targets are word aligned; the byte offset of a redirect is ignored.
   function automatic logic [31:0] word_align(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pipeifq_ifq_fifo.sv
// rtl/pipeifq_ifq_fifo.sv - DEPTH x 64-bit {pc, instruction} queue with synchronous flush
module ifq_fifo
   import pipeifq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     flush,
   input  logic                     push,
   input  logic [63:0]              push_data,
   input  logic                     pop,
   output logic [63:0]              head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [63:0]   mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;

   // Entry storage; contents need no reset because validity is carried by count.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wptr] <= push_data;
      end
   end

   // Pointers and occupancy; a flush empties the queue and beats any push or pop.
   always_ff @(posedge clock or posedge resetn) begin
      if (resetn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head_data = mem[rptr];
   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));

endmodule

// File: rtl/pipeifq.sv
// rtl/pipeifq.sv - instruction prefetch queue between instruction memory and the IF stage
module pipeifq
   import pipeifq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 10
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [31:0]   mem_rdata,
   output logic          ifq_valid,
   output logic [31:0]   ifq_pc,
   output logic [31:0]   ifq_ins,
   output logic [31:0]   ifq_pc4,
   input  logic          ifq_ready
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t  state;
   fetch_state_t  state_next;
   logic [31:0]   fpc;
   logic [31:0]   fpc_next;
   logic [AW-1:0] req_addr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_after;
   logic          full;
   logic          empty;
   logic          pop;
   logic          push;
   logic          space_idle;
   logic          space_req;
   logic [63:0]   head_data;

   assign pop  = ifq_valid & ifq_ready;
   assign push = (state == ST_REQ) & mem_ack & ~redirect;

   // Room for a new request once this cycle's pop is counted as freed space.
   assign space_idle  = ~full | pop;
   // Occupancy after the response being pushed now and this cycle's pop.
   assign count_after = count + CW'(1) - CW'(pop);
   assign space_req   = (count_after < CW'(DEPTH));

   ifq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .resetn    (resetn),
      .flush     (redirect),
      .push      (push),
      .push_data ({fpc, mem_rdata}),
      .pop       (pop),
      .head_data (head_data),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   // Fetch sequencing: next state and next fetch pointer.
   always_comb begin
      state_next = state;
      fpc_next   = fpc;
      case (state)
         ST_IDLE: begin
            if (redirect) begin
               fpc_next   = word_align(redirect_pc);
               state_next = ST_REQ;
            end else if (space_idle) begin
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (redirect) begin
               // A flushed queue always has room, so an acked redirect refetches at once.
               fpc_next   = word_align(redirect_pc);
               state_next = mem_ack ? ST_REQ : ST_DROP;
            end else if (mem_ack) begin
               fpc_next   = fpc + 32'd4;
               state_next = space_req ? ST_REQ : ST_IDLE;
            end
         end
         ST_DROP: begin
            if (redirect) begin
               fpc_next = word_align(redirect_pc);
            end
            if (mem_ack) begin
               state_next = ST_REQ;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State, fetch pointer and the registered request address; the address is
   // only reloaded when a fresh request starts, so it holds through DROP.
   always_ff @(posedge clock or posedge resetn) begin
      if (resetn) begin
         state    <= ST_IDLE;
         fpc      <= RESET_PC;
         req_addr <= '0;
      end else begin
         state <= state_next;
         fpc   <= fpc_next;
         if (state_next == ST_REQ) begin
            req_addr <= fpc_next[AW+1:2];
         end
      end
   end

   assign mem_req   = (state != ST_IDLE);
   assign mem_addr  = req_addr;

   // Head outputs read as a nop at pc 0 whenever the queue is empty.
   assign ifq_valid = ~empty;
   assign ifq_pc    = empty ? 32'h0    : head_data[63:32];
   assign ifq_ins   = empty ? NOP_WORD : head_data[31:0];
   assign ifq_pc4   = empty ? 32'h0    : head_data[63:32] + 32'd4;

endmodule

// File: tb/tb_pipeifq.sv
// tb/tb_pipeifq.sv - self-checking bench for pipeifq with a random memory and consumer
module tb_pipeifq;

   localparam int DEPTH = 4;
   localparam int AW    = 10;

   logic          clock       = 1'b0;
   logic          resetn      = 1'b0;
   logic          redirect    = 1'b0;
   logic [31:0]   redirect_pc = 32'h0;
   logic          mem_ack     = 1'b0;
   logic [31:0]   mem_rdata   = 32'h0;
   logic          ifq_ready   = 1'b0;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          ifq_valid;
   logic [31:0]   ifq_pc;
   logic [31:0]   ifq_ins;
   logic [31:0]   ifq_pc4;

   int checks = 0;
   int errors = 0;

   // Memory responder state
   bit            pend = 1'b0;
   logic [AW-1:0] pend_addr = '0;
   int            wait_cnt = 0;
   int            lat = 0;
   int            acks = 0;

   // Consumer reference: expected pc stream
   logic [31:0]   exp_pc;
   bit            last_redir;
   int            pops;

   always #5 clock = ~clock;

   pipeifq #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .ifq_valid   (ifq_valid),
      .ifq_pc      (ifq_pc),
      .ifq_ins     (ifq_ins),
      .ifq_pc4     (ifq_pc4),
      .ifq_ready   (ifq_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [AW-1:0] a);
      return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0003);
   endfunction

   task automatic step();
      @(negedge clock);
   endtask

   task automatic do_reset();
      redirect  = 1'b0;
      mem_ack   = 1'b0;
      ifq_ready = 1'b0;
      resetn    = 1'b1;
      step();
      step();
      resetn = 1'b0;
      pend   = 1'b0;
   endtask

   // Memory model: random latency up to max_lat, address must hold while pending.
   task automatic mem_respond(input int max_lat);
      if (mem_req) begin
         if (!pend) begin
            pend      = 1'b1;
            pend_addr = mem_addr;
            wait_cnt  = 0;
            lat       = int'($urandom_range(max_lat, 0));
         end else begin
            check("addr_hold", mem_addr, pend_addr);
         end
         if (wait_cnt == lat) begin
            mem_ack   = 1'b1;
            mem_rdata = word_of(mem_addr);
            pend      = 1'b0;
            acks++;
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            wait_cnt++;
         end
      end else begin
         mem_ack = 1'b0;
      end
   endtask

   initial begin
      // Reset values
      resetn = 1'b1;
      step();
      step();
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_valid", ifq_valid, 0);
      check("rst_pc", ifq_pc, 0);
      check("rst_ins", ifq_ins, 0);
      check("rst_pc4", ifq_pc4, 0);
      resetn = 1'b0;

      // Back-to-back fetch with ack every cycle
      ifq_ready = 1'b1;
      step();
      check("first_req", mem_req, 1);
      check("first_addr", mem_addr, 0);
      mem_ack   = 1'b1;
      mem_rdata = word_of(mem_addr);
      for (int i = 0; i < 4; i++) begin
         step();
         check("seq_valid", ifq_valid, 1);
         check("seq_pc", ifq_pc, 32'(4 * i));
         check("seq_pc4", ifq_pc4, 32'(4 * i + 4));
         check("seq_ins", ifq_ins, word_of(AW'(i)));
         mem_ack   = 1'b1;
         mem_rdata = word_of(mem_addr);
      end
      mem_ack = 1'b0;

      // Queue fills with consumer stalled, then one pop frees one slot
      do_reset();
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (i >= 6) check("full_req_low", mem_req, 0);
         mem_respond(0);
      end
      check("full_acks", acks, 4);
      check("full_valid", ifq_valid, 1);
      check("full_head", ifq_pc, 0);
      ifq_ready = 1'b1;
      acks = 0;
      step();
      ifq_ready = 1'b0;
      check("refill_req", mem_req, 1);
      check("refill_addr", mem_addr, 4);
      check("pop_head", ifq_pc, 4);
      mem_respond(0);
      for (int i = 0; i < 5; i++) begin
         step();
         mem_respond(0);
      end
      check("refill_acks", acks, 1);
      check("refill_req_low", mem_req, 0);

      // Redirect during a slow request: stale word dropped
      do_reset();
      step();
      check("drop_req", mem_req, 1);
      check("drop_addr0", mem_addr, 0);
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      step();
      redirect = 1'b0;
      check("drop_hold_req", mem_req, 1);
      check("drop_hold_addr", mem_addr, 0);
      step();
      mem_ack   = 1'b1;
      mem_rdata = word_of(0);
      step();
      check("drop_discard", ifq_valid, 0);
      check("drop_new_req", mem_req, 1);
      check("drop_new_addr", mem_addr, 32'h40);
      mem_ack   = 1'b1;
      mem_rdata = word_of(mem_addr);
      step();
      mem_ack = 1'b0;
      check("drop_head_pc", ifq_pc, 32'h100);
      check("drop_head_ins", ifq_ins, word_of(AW'(32'h40)));

      // Redirect together with ack and pop
      do_reset();
      step();
      mem_ack   = 1'b1;
      mem_rdata = word_of(mem_addr);
      step();
      check("same_pre_valid", ifq_valid, 1);
      check("same_pre_addr", mem_addr, 1);
      mem_ack     = 1'b1;
      mem_rdata   = word_of(mem_addr);
      ifq_ready   = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0204;
      step();
      redirect  = 1'b0;
      ifq_ready = 1'b0;
      check("same_flush", ifq_valid, 0);
      check("same_req", mem_req, 1);
      check("same_addr", mem_addr, 32'h81);
      mem_ack   = 1'b1;
      mem_rdata = word_of(mem_addr);
      step();
      mem_ack = 1'b0;
      check("same_head_pc", ifq_pc, 32'h204);

      // Asynchronous reset mid-request with three entries held
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         mem_ack   = 1'b1;
         mem_rdata = word_of(mem_addr);
      end
      step();
      mem_ack = 1'b0;
      check("mid_valid", ifq_valid, 1);
      check("mid_req", mem_req, 1);
      check("mid_addr", mem_addr, 3);
      #2 resetn = 1'b1;
      #1;
      check("async_req", mem_req, 0);
      check("async_addr", mem_addr, 0);
      check("async_valid", ifq_valid, 0);
      check("async_pc", ifq_pc, 0);
      check("async_ins", ifq_ins, 0);
      check("async_pc4", ifq_pc4, 0);
      step();
      resetn = 1'b0;
      pend   = 1'b0;
      step();
      check("restart_req", mem_req, 1);
      check("restart_addr", mem_addr, 0);

      // Unaligned redirect target
      do_reset();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      step();
      redirect = 1'b0;
      check("unal_req", mem_req, 1);
      check("unal_addr", mem_addr, 32'h40);
      mem_ack   = 1'b1;
      mem_rdata = word_of(mem_addr);
      step();
      mem_ack = 1'b0;
      check("unal_pc", ifq_pc, 32'h100);
      check("unal_pc4", ifq_pc4, 32'h104);

      // Random memory latency, consumer stalls and redirects against the pc stream model
      do_reset();
      exp_pc     = 32'h0;
      last_redir = 1'b0;
      pops       = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         if (last_redir) check("rnd_flush_empty", ifq_valid, 0);
         redirect  = !last_redir && ($urandom_range(24, 0) == 0);
         ifq_ready = ($urandom_range(3, 0) != 0);
         if (ifq_valid && ifq_ready && !redirect) begin
            check("rnd_pc", ifq_pc, exp_pc);
            check("rnd_ins", ifq_ins, word_of(exp_pc[AW+1:2]));
            check("rnd_pc4", ifq_pc4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            pops++;
         end
         if (redirect) begin
            if ($urandom_range(7, 0) == 0)
               redirect_pc = 32'hFFFF_FFF4 | 32'($urandom_range(3, 0));
            else
               redirect_pc = $urandom;
            exp_pc = {redirect_pc[31:2], 2'b00};
         end
         last_redir = redirect;
         mem_respond(3);
      end
      redirect  = 1'b0;
      ifq_ready = 1'b0;
      mem_ack   = 1'b0;
      check("rnd_progress", 32'(pops > 300), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
